// File: rtl/master_state_sm.sv
// Master controller: conditions four raw push-buttons, recognises the UP -> RIGHT -> DOWN
// unlock sequence, drives the MASTER_STATE bus and flags completion of the LED sweep.
module master_state_sm #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES  = 500000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_U,
  input  logic       BTN_R,
  input  logic       BTN_D,
  input  logic       BTN_L,
  input  logic [3:0] LED_SM_STATE,
  output logic [1:0] MASTER_STATE,
  output logic       SEQ_ERR,
  output logic       DONE
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Press vector bit order: [0]=U, [1]=R, [2]=D, [3]=L
  localparam logic [3:0] P_U = 4'b0001;
  localparam logic [3:0] P_R = 4'b0010;
  localparam logic [3:0] P_D = 4'b0100;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GOT_U = 2'b01,
    GOT_R = 2'b10,
    RUN   = 2'b11
  } state_t;

  logic [3:0]    btn_raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    deb;
  logic [3:0]    deb_prev;
  logic [3:0]    press;
  logic [DW-1:0] deb_cnt [4];
  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign btn_raw      = {BTN_L, BTN_D, BTN_R, BTN_U};
  assign MASTER_STATE = state;
  assign tmo_hit      = (tmo_cnt == TMO_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_prev <= '0;
      press    <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make sync1 -> sync2 shift one stage per edge;
      // blocking ones would collapse the synchroniser into a single flop.
      sync1    <= btn_raw;
      sync2    <= sync1;
      deb_prev <= deb;
      press    <= deb & ~deb_prev;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      tmo_cnt <= '0;
      SEQ_ERR <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      // NOTE: defaults come first and the case below overrides them, so every
      // register gets a defined next value on every path.
      SEQ_ERR <= 1'b0;
      tmo_cnt <= '0;
      DONE    <= (state == RUN) && (LED_SM_STATE == 4'hF);
      case (state)
        IDLE: begin
          if (press == P_U) state <= GOT_U;
        end
        GOT_U: begin
          // A press in the timeout cycle wins over the timeout itself
          if (press == P_R) begin
            state <= GOT_R;
          end else if ((press != '0) || tmo_hit) begin
            state   <= IDLE;
            SEQ_ERR <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        GOT_R: begin
          if (press == P_D) begin
            state <= RUN;
          end else if ((press != '0) || tmo_hit) begin
            state   <= IDLE;
            SEQ_ERR <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_master_state_sm.sv
// Scoreboard bench for master_state_sm: stimulus queues expected output changes with
// their cycle of arrival; a monitor pops and compares whenever the outputs change.
module tb_master_state_sm;

  logic       CLK;
  logic       RESET;
  logic [3:0] btn;
  logic [3:0] led;
  logic [1:0] MASTER_STATE;
  logic       SEQ_ERR;
  logic       DONE;

  master_state_sm #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .BTN_U       (btn[0]),
    .BTN_R       (btn[1]),
    .BTN_D       (btn[2]),
    .BTN_L       (btn[3]),
    .LED_SM_STATE(led),
    .MASTER_STATE(MASTER_STATE),
    .SEQ_ERR     (SEQ_ERR),
    .DONE        (DONE)
  );

  localparam logic [3:0] B_U = 4'b0001;
  localparam logic [3:0] B_R = 4'b0010;
  localparam logic [3:0] B_D = 4'b0100;
  localparam logic [3:0] B_L = 4'b1000;

  typedef struct {
    logic [1:0] ms;
    logic       se;
    logic       dn;
    int         cyc;
    string      name;
  } ev_t;

  ev_t exp_q[$];
  int  cyc      = 0;
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  mon_en   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic expect_ev(input logic [1:0] ms, input logic se, input logic dn,
                           input int at, input string name);
    ev_t e;
    e.ms = ms; e.se = se; e.dn = dn; e.cyc = at; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic push_btn(input logic [3:0] mask, input int hold, input int gap);
    btn = btn | mask;
    tick(hold);
    btn = btn & ~mask;
    tick(gap);
  endtask

  task automatic pulse_reset();
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    check("reset MASTER_STATE", MASTER_STATE, 2'b00);
    check("reset SEQ_ERR", SEQ_ERR, 1'b0);
    check("reset DONE", DONE, 1'b0);
  endtask

  // Monitor: every change of {MASTER_STATE, SEQ_ERR, DONE} must match the next queued event
  initial begin : monitor
    logic [3:0] prev;
    logic [3:0] cur;
    ev_t        e;
    prev = 4'b0000;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        cur = {MASTER_STATE, SEQ_ERR, DONE};
        if (cur !== prev) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected output change: got %0h, expected %0h (cycle %0d)",
                     cur, prev, cyc);
          end else begin
            e = exp_q.pop_front();
            check({e.name, " value"}, {28'd0, cur}, {28'd0, e.ms, e.se, e.dn});
            check({e.name, " cycle"}, cyc, e.cyc);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int t;
    RESET = 1'b1;
    btn   = '0;
    led   = '0;
    tick(3);
    RESET = 1'b0;
    check("reset MASTER_STATE", MASTER_STATE, 2'b00);
    check("reset SEQ_ERR", SEQ_ERR, 1'b0);
    check("reset DONE", DONE, 1'b0);
    mon_en = 1'b1;
    tick(2);

    // Clean unlock; each later press lands exactly on the timeout cycle and must win
    t = cyc;
    expect_ev(2'b01, 1'b0, 1'b0, t + 8,  "U to GOT_U");
    expect_ev(2'b10, 1'b0, 1'b0, t + 28, "R to GOT_R");
    expect_ev(2'b11, 1'b0, 1'b0, t + 48, "D to RUN");
    push_btn(B_U, 10, 10);
    push_btn(B_R, 10, 10);
    push_btn(B_D, 10, 10);

    // RUN ignores presses; DONE follows LED_SM_STATE==F one cycle later
    push_btn(B_U, 10, 10);
    push_btn(B_R, 10, 10);
    push_btn(B_D, 10, 10);
    push_btn(B_L, 10, 10);
    for (int v = 1; v <= 8; v++) begin
      led = 4'(v);
      tick(1);
    end
    t = cyc;
    expect_ev(2'b11, 1'b0, 1'b1, t + 1, "DONE rise");
    led = 4'hF;
    tick(3);
    push_btn(B_U, 10, 10);
    check("RUN holds after press", MASTER_STATE, 2'b11);

    // Reset out of RUN with DONE high
    t = cyc;
    expect_ev(2'b00, 1'b0, 1'b0, t + 1, "reset from RUN");
    pulse_reset();

    // IDLE ignores LED_SM_STATE==F and non-U presses
    push_btn(B_R, 10, 10);
    push_btn(B_D, 10, 10);
    push_btn(B_L, 10, 10);
    check("IDLE holds", MASTER_STATE, 2'b00);
    check("IDLE DONE low", DONE, 1'b0);
    led = 4'h0;
    tick(2);

    // Wrong press D in GOT_U
    t = cyc;
    expect_ev(2'b01, 1'b0, 1'b0, t + 8,  "wrongD enter GOT_U");
    expect_ev(2'b00, 1'b1, 1'b0, t + 20, "wrongD abort");
    expect_ev(2'b00, 1'b0, 1'b0, t + 21, "wrongD pulse end");
    push_btn(B_U, 10, 2);
    push_btn(B_D, 10, 10);

    // R and L together in GOT_U
    t = cyc;
    expect_ev(2'b01, 1'b0, 1'b0, t + 8,  "RL enter GOT_U");
    expect_ev(2'b00, 1'b1, 1'b0, t + 20, "RL abort");
    expect_ev(2'b00, 1'b0, 1'b0, t + 21, "RL pulse end");
    push_btn(B_U, 10, 2);
    push_btn(B_R | B_L, 10, 10);

    // Wrong press L in GOT_R
    t = cyc;
    expect_ev(2'b01, 1'b0, 1'b0, t + 8,  "wrongL enter GOT_U");
    expect_ev(2'b10, 1'b0, 1'b0, t + 20, "wrongL enter GOT_R");
    expect_ev(2'b00, 1'b1, 1'b0, t + 32, "wrongL abort");
    expect_ev(2'b00, 1'b0, 1'b0, t + 33, "wrongL pulse end");
    push_btn(B_U, 10, 2);
    push_btn(B_R, 10, 2);
    push_btn(B_L, 10, 10);

    // 3-cycle R glitch is rejected, then timeout 20 cycles after entry
    t = cyc;
    expect_ev(2'b01, 1'b0, 1'b0, t + 8,  "glitch enter GOT_U");
    expect_ev(2'b00, 1'b1, 1'b0, t + 28, "timeout abort");
    expect_ev(2'b00, 1'b0, 1'b0, t + 29, "timeout pulse end");
    push_btn(B_U, 10, 2);
    push_btn(B_R, 3, 10);
    check("GOT_U holds through glitch", MASTER_STATE, 2'b01);
    tick(10);

    // Reset in GOT_R with D held across it; D alone is ignored afterwards in IDLE
    t = cyc;
    expect_ev(2'b01, 1'b0, 1'b0, t + 8,  "hold enter GOT_U");
    expect_ev(2'b10, 1'b0, 1'b0, t + 20, "hold enter GOT_R");
    expect_ev(2'b00, 1'b0, 1'b0, t + 29, "reset from GOT_R");
    push_btn(B_U, 10, 2);
    push_btn(B_R, 10, 2);
    btn = btn | B_D;
    tick(4);
    pulse_reset();
    tick(15);
    btn = btn & ~B_D;
    tick(10);
    check("IDLE after held D", MASTER_STATE, 2'b00);

    // Conditioning still works after reset: fresh U, then timeout
    t = cyc;
    expect_ev(2'b01, 1'b0, 1'b0, t + 8,  "post-reset GOT_U");
    expect_ev(2'b00, 1'b1, 1'b0, t + 28, "post-reset timeout");
    expect_ev(2'b00, 1'b0, 1'b0, t + 29, "post-reset pulse end");
    push_btn(B_U, 10, 10);
    tick(20);

    check("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
